// File: rtl/deskew_regs_pkg.sv
// Purpose: shared constants, the write-beat payload type and the byte-merge helper
//          for the Deskew AXI4-Lite register block.
package deskew_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 3;

    // Word indices (byte address bits [4:2])
    localparam logic [IDX_W-1:0] IDX_CTRL   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_SRC    = 3'd1;
    localparam logic [IDX_W-1:0] IDX_DST    = 3'd2;
    localparam logic [IDX_W-1:0] IDX_SIZE   = 3'd3;
    localparam logic [IDX_W-1:0] IDX_STATUS = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_skid_hold.sv
// Purpose: one-entry holding register for an AXI valid/ready channel. The entry is
//          presented combinationally in the acceptance cycle so a consumer can use it
//          immediately; otherwise it is parked until popped.
// Ports: clk, rst_n; valid/ready/data = upstream channel (ready registered);
//        avail_c/head_c = entry present and its payload; pop = consumer takes the entry.
module axil_skid_hold #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    output logic         ready,
    input  logic [W-1:0] data,
    output logic         avail_c,
    output logic [W-1:0] head_c,
    input  logic         pop
);

    logic         full;
    logic [W-1:0] q;
    logic         take_c;
    logic         full_next_c;

    assign take_c      = valid & ready;
    assign avail_c     = full | take_c;
    assign head_c      = full ? q : data;
    assign full_next_c = (full | take_c) & ~pop;

    // ready mirrors "holder empty" but stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            ready <= 1'b0;
            q     <= '0;
        end else begin
            full  <= full_next_c;
            ready <= ~full_next_c;
            if (take_c && !pop) q <= data;
        end
    end

endmodule

// File: rtl/deskew_axil_regs.sv
// Purpose: AXI4-Lite register slave for the Deskew core: CTRL/SRC/DST/SIZE config
//          registers, STATUS with sticky done (W1C), one-cycle start pulse.
// Ports: s00_axi_* = AXI4-Lite slave (aclk, async active-low aresetn);
//        ctrl_o/src_addr_o/dst_addr_o/size_o = register contents; start_o = pulse;
//        busy_i/done_i = core status (done_i is a pulse).
module deskew_axil_regs
    import deskew_regs_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     src_addr_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     dst_addr_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     size_o,
    output logic                              start_o,
    input  logic                              busy_i,
    input  logic                              done_i
);

    logic              clk;
    logic              rst_n;
    logic              aw_avail_c;
    logic [IDX_W-1:0]  aw_idx_c;
    logic              w_avail_c;
    wbeat_t            w_in_c;
    wbeat_t            w_head_c;
    logic              commit_c;
    logic              done_clr_c;
    logic              done_sticky;
    logic              ar_take_c;
    logic              rvalid_next_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              unused_ok;

    assign clk    = s00_axi_aclk;
    assign rst_n  = s00_axi_aresetn;
    assign w_in_c = '{data: s00_axi_wdata, strb: s00_axi_wstrb};

    // Protection bits and byte offset within a word carry no meaning here
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    axil_skid_hold #(.W(IDX_W)) u_aw_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (s00_axi_awvalid),
        .ready   (s00_axi_awready),
        .data    (s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]),
        .avail_c (aw_avail_c),
        .head_c  (aw_idx_c),
        .pop     (commit_c)
    );

    axil_skid_hold #(.W($bits(wbeat_t))) u_w_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (s00_axi_wvalid),
        .ready   (s00_axi_wready),
        .data    (w_in_c),
        .avail_c (w_avail_c),
        .head_c  (w_head_c),
        .pop     (commit_c)
    );

    // A write commits once address and data are both present and no B is outstanding
    assign commit_c   = aw_avail_c & w_avail_c & ~s00_axi_bvalid;
    assign done_clr_c = commit_c & (aw_idx_c == IDX_STATUS) & w_head_c.data[STATUS_DONE_BIT];

    // Register file and start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_o      <= '0;
            src_addr_o  <= '0;
            dst_addr_o  <= '0;
            size_o      <= '0;
            start_o     <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            if (commit_c) begin
                case (aw_idx_c)
                    IDX_CTRL: ctrl_o     <= strb_merge(ctrl_o, w_head_c.data, w_head_c.strb);
                    IDX_SRC:  src_addr_o <= strb_merge(src_addr_o, w_head_c.data, w_head_c.strb);
                    IDX_DST:  dst_addr_o <= strb_merge(dst_addr_o, w_head_c.data, w_head_c.strb);
                    IDX_SIZE: size_o     <= strb_merge(size_o, w_head_c.data, w_head_c.strb);
                    default:  ;
                endcase
            end
            start_o     <= commit_c & (aw_idx_c == IDX_CTRL) & w_head_c.strb[0] & w_head_c.data[0];
            // A done pulse wins over a simultaneous clear
            done_sticky <= done_i | (done_sticky & ~done_clr_c);
        end
    end

    // Write response channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
        end else if (commit_c) begin
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= (aw_idx_c <= IDX_STATUS) ? RESP_OKAY : RESP_SLVERR;
        end else if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
        end
    end

    assign ar_idx_c      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_take_c     = s00_axi_arvalid & s00_axi_arready;
    assign rvalid_next_c = ar_take_c | (s00_axi_rvalid & ~s00_axi_rready);

    // Read mux sees pre-commit register values
    always_comb begin
        rd_data_c = '0;
        case (ar_idx_c)
            IDX_CTRL:   rd_data_c = ctrl_o;
            IDX_SRC:    rd_data_c = src_addr_o;
            IDX_DST:    rd_data_c = dst_addr_o;
            IDX_SIZE:   rd_data_c = size_o;
            IDX_STATUS: begin
                rd_data_c[STATUS_BUSY_BIT] = busy_i;
                rd_data_c[STATUS_DONE_BIT] = done_sticky;
            end
            default:    rd_data_c = '0;
        endcase
    end

    // Read channel; arready tracks ~rvalid but stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            s00_axi_arready <= ~rvalid_next_c;
            s00_axi_rvalid  <= rvalid_next_c;
            if (ar_take_c) begin
                s00_axi_rdata <= rd_data_c;
                s00_axi_rresp <= (ar_idx_c <= IDX_STATUS) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_deskew_axil_regs.sv
// Purpose: directed self-checking bench for deskew_axil_regs.
module tb_deskew_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ctrl_o, src_addr_o, dst_addr_o, size_o;
    logic        start_o;
    logic        busy_i;
    logic        done_i;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    deskew_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_o          (ctrl_o),
        .src_addr_o      (src_addr_o),
        .dst_addr_o      (dst_addr_o),
        .size_o          (size_o),
        .start_o         (start_o),
        .busy_i          (busy_i),
        .done_i          (done_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        n_checks++;
        n_fails++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  cnt;
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        cnt = 0;
        while ((awvalid || wvalid) && cnt < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            cnt++;
        end
        if (awvalid || wvalid) begin
            timed_out("wr_addr_data");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            step();
            cnt++;
        end
        if (!bvalid) timed_out("wr_bvalid");
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cnt;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        cnt = 0;
        while (!arready && cnt < 20) begin
            step();
            cnt++;
        end
        if (!arready) timed_out("rd_arready");
        step();
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin
            step();
            cnt++;
        end
        if (!rvalid) timed_out("rd_rvalid");
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    // Best-case write (both holders empty): commit at the accepting edge; checks start_o
    task automatic fast_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic exp_start, input string tag);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, "_start"}, 32'(start_o), 32'(exp_start));
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check({tag, "_start_drop"}, 32'(start_o), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        busy_i = 1'b0; done_i = 1'b0;
        step();
        step();

        // Reset state
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_resps",   32'({bresp, rresp}), 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_start",   32'(start_o), 32'd0);
        check("rst_ctrl",    ctrl_o, 32'd0);
        check("rst_size",    size_o, 32'd0);

        rst_n = 1'b1;
        step();
        step();

        // Basic writes and readback
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
            check($sformatf("wr%0d_bresp", i), 32'(resp), 32'd0);
        end
        check("ctrl_o_1", ctrl_o, 32'd1);
        check("src_o_2",  src_addr_o, 32'd2);
        check("dst_o_3",  dst_addr_o, 32'd3);
        check("size_o_4", size_o, 32'd4);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), rd, resp);
            check($sformatf("rd%0d_data", i), rd, 32'(i + 1));
            check($sformatf("rd%0d_rresp", i), 32'(resp), 32'd0);
        end

        // W three cycles ahead of AW
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst_wready_low", 32'(wready), 32'd0);
        step();
        step();
        check("wfirst_no_b", 32'(bvalid), 32'd0);
        awaddr = 5'h04; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_bresp",  32'(bresp),  32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wfirst_b_done", 32'(bvalid), 32'd0);
        check("wfirst_wready", 32'(wready), 32'd1);
        axi_read(5'h04, rd, resp);
        check("wfirst_readback", rd, 32'hA5A5A5A5);

        // Byte-strobe merge: only lane 1 (0x12) lands
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(5'h04, 32'h00001234, 4'b0010, resp);
        axi_read(5'h04, rd, resp);
        check("strb_readback", rd, 32'hFFFF12FF);

        // Back-pressure on B: second write parks in the holders
        awaddr = 5'h08; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        check("bp_bvalid1", 32'(bvalid), 32'd1);
        check("bp_dst",     dst_addr_o, 32'h11);
        awaddr = 5'h0C; wdata = 32'h22;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_awready_low", 32'(awready), 32'd0);
        check("bp_wready_low",  32'(wready),  32'd0);
        step();
        step();
        step();
        check("bp_bvalid_held", 32'(bvalid), 32'd1);
        check("bp_size_old",    size_o, 32'd4);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp_b_done",   32'(bvalid), 32'd0);
        check("bp_size_old2", size_o, 32'd4);
        step();
        check("bp_bvalid2",  32'(bvalid), 32'd1);
        check("bp_size_new", size_o, 32'h22);
        check("bp_awready",  32'(awready), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;

        // Start pulse
        fast_write(5'h00, 32'h1, 4'hF, 1'b1, "start_idle");
        busy_i = 1'b1;
        fast_write(5'h00, 32'h1, 4'hF, 1'b1, "start_busy");
        busy_i = 1'b0;
        fast_write(5'h00, 32'h00000101, 4'b0010, 1'b0, "start_nostrb");
        check("ctrl_not_selfclr", ctrl_o, 32'h00000101);

        // STATUS: sticky done, busy passthrough, W1C, set-wins
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        axi_read(5'h10, rd, resp);
        check("status_done", rd, 32'h2);
        busy_i = 1'b1;
        axi_read(5'h10, rd, resp);
        check("status_busy_done", rd, 32'h3);
        busy_i = 1'b0;
        axi_write(5'h10, 32'h2, 4'hF, resp);
        check("status_w1c_bresp", 32'(resp), 32'd0);
        axi_read(5'h10, rd, resp);
        check("status_cleared", rd, 32'h0);
        awaddr = 5'h10; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; done_i = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; done_i = 1'b0;
        bready = 1'b1;
        step();
        bready = 1'b0;
        axi_read(5'h10, rd, resp);
        check("status_set_wins", rd, 32'h2);

        // Unmapped slot
        axi_write(5'h18, 32'hDEADBEEF, 4'hF, resp);
        check("unmap_bresp", 32'(resp), 32'd2);
        axi_read(5'h18, rd, resp);
        check("unmap_rdata", rd, 32'd0);
        check("unmap_rresp", 32'(resp), 32'd2);
        check("unmap_no_side", ctrl_o, 32'h00000101);

        // Reset in the middle of outstanding B and R
        awaddr = 5'h04; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        check("mid_bvalid_pre", 32'(bvalid), 32'd1);
        check("mid_rvalid_pre", 32'(rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_bvalid", 32'(bvalid), 32'd0);
        check("mid_rvalid", 32'(rvalid), 32'd0);
        check("mid_rdata",  rdata, 32'd0);
        check("mid_ready",  32'({awready, wready, arready}), 32'd0);
        check("mid_regs",   ctrl_o | src_addr_o | dst_addr_o | size_o, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        axi_read(5'h04, rd, resp);
        check("post_rst_src", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
